// File: rtl/issue_queue_if.sv
// Program-load, free-count, branch-resolve and issue-slot signals of the issue queue.
// master = program loader / core side, slave = the issue queue itself.
interface issue_queue_if #(
  parameter int IW      = 16,
  parameter int DEPTH   = 64,
  parameter int ISSUE_W = 2,
  parameter int FREE_W  = 3,
  parameter int AW      = $clog2(DEPTH)
);
  logic                    Run;
  logic                    prog_we;
  logic [AW-1:0]           prog_addr;
  logic [IW-1:0]           prog_data;
  logic [AW:0]             prog_len;
  logic [FREE_W-1:0]       add_free;
  logic [FREE_W-1:0]       ld_free;
  logic [FREE_W-1:0]       sd_free;
  logic                    br_resolve;
  logic                    br_taken;
  logic [AW-1:0]           br_target;
  logic [ISSUE_W-1:0]      issue_valid;
  logic [2*ISSUE_W-1:0]    issue_class;
  logic [IW*ISSUE_W-1:0]   issue_inst;
  logic [AW*ISSUE_W-1:0]   issue_pc;
  logic [AW:0]             pc;
  logic                    branch_pending;
  logic                    done;

  modport master (
    output Run, prog_we, prog_addr, prog_data, prog_len,
           add_free, ld_free, sd_free, br_resolve, br_taken, br_target,
    input  issue_valid, issue_class, issue_inst, issue_pc, pc, branch_pending, done
  );

  modport slave (
    input  Run, prog_we, prog_addr, prog_data, prog_len,
           add_free, ld_free, sd_free, br_resolve, br_taken, br_target,
    output issue_valid, issue_class, issue_inst, issue_pc, pc, branch_pending, done
  );
endinterface

// File: rtl/issue_queue.sv
// In-order multi-issue unit: reads ISSUE_W instructions at pc, issues them to the
// adder RS / load / store buffers subject to free counts, and stalls behind BNE.D.

// Per-slot opcode decode: 00 adder, 01 load, 10 store, 11 none.
module iq_dec (
  input  logic [3:0] op,
  output logic [1:0] cls,
  output logic       is_br
);
  always_comb begin
    cls = 2'b11;
    case (op)
      4'h0, 4'h1, 4'h2: cls = 2'b00;
      4'h3:             cls = 2'b01;
      4'h4:             cls = 2'b10;
      default:          cls = 2'b11;
    endcase
    is_br = (op == 4'h2);
  end
endmodule

module issue_queue #(
  parameter int IW      = 16,
  parameter int DEPTH   = 64,
  parameter int ISSUE_W = 2,
  parameter int FREE_W  = 3,
  parameter int AW      = $clog2(DEPTH)
) (
  input logic          Clock,
  input logic          Reset,
  issue_queue_if.slave bus
);
  // One extra bit over the pc so pc+k never wraps before the prog_len compare.
  localparam int PW   = AW + 2;
  localparam int CMPW = (FREE_W > 3) ? FREE_W : 3;

  logic [IW-1:0] mem [DEPTH];

  logic [AW:0]                     pc_q;
  logic                            bp_q;
  logic [ISSUE_W-1:0]              iv_q;
  logic [ISSUE_W-1:0][1:0]         cls_q;
  logic [ISSUE_W-1:0][IW-1:0]      inst_q;
  logic [ISSUE_W-1:0][AW-1:0]      pcs_q;

  logic [ISSUE_W-1:0][PW-1:0]      s_pc;
  logic [ISSUE_W-1:0][IW-1:0]      s_inst;
  logic [ISSUE_W-1:0][1:0]         s_cls;
  logic [ISSUE_W-1:0]              s_br;

  logic                            issue_cyc, go, br_hit;
  logic [2:0]                      n_cons;
  logic [3:0][2:0]                 cnt;
  logic [FREE_W-1:0]               fr;
  logic [ISSUE_W-1:0]              nv;
  logic [ISSUE_W-1:0][1:0]         ncls;
  logic [ISSUE_W-1:0][IW-1:0]      ninst;
  logic [ISSUE_W-1:0][AW-1:0]      npc;

  always_ff @(posedge Clock) begin
    if (bus.prog_we) mem[bus.prog_addr] <= bus.prog_data;
  end

  for (genvar k = 0; k < ISSUE_W; k++) begin : g_lane
    assign s_pc[k]   = PW'(pc_q) + PW'(k);
    assign s_inst[k] = mem[s_pc[k][AW-1:0]];
    iq_dec u_dec (.op(s_inst[k][3:0]), .cls(s_cls[k]), .is_br(s_br[k]));
  end

  assign issue_cyc = bus.Run && !bp_q && !bus.br_resolve;

  // Walk slots in order; the first slot that cannot go closes the cycle.
  always_comb begin
    go     = issue_cyc;
    br_hit = 1'b0;
    n_cons = '0;
    cnt    = '0;
    fr     = '0;
    nv     = '0;
    ncls   = '1;
    ninst  = '0;
    npc    = '0;
    for (int k = 0; k < ISSUE_W; k++) begin
      case (s_cls[k])
        2'b00:   fr = bus.add_free;
        2'b01:   fr = bus.ld_free;
        default: fr = bus.sd_free;
      endcase
      if (go && (s_pc[k] < PW'(bus.prog_len))) begin
        if (s_cls[k] == 2'b11) begin
          n_cons = n_cons + 3'd1;
        end else if (CMPW'(fr) > CMPW'(cnt[s_cls[k]])) begin
          nv[k]          = 1'b1;
          ncls[k]        = s_cls[k];
          ninst[k]       = s_inst[k];
          npc[k]         = s_pc[k][AW-1:0];
          cnt[s_cls[k]]  = cnt[s_cls[k]] + 3'd1;
          n_cons         = n_cons + 3'd1;
          if (s_br[k]) begin
            br_hit = 1'b1;
            go     = 1'b0;
          end
        end else begin
          go = 1'b0;
        end
      end else begin
        go = 1'b0;
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      pc_q   <= '0;
      bp_q   <= 1'b0;
      iv_q   <= '0;
      cls_q  <= '1;
      inst_q <= '0;
      pcs_q  <= '0;
    end else begin
      iv_q   <= nv;
      cls_q  <= ncls;
      inst_q <= ninst;
      pcs_q  <= npc;
      if (bp_q && bus.br_resolve) begin
        // Not-taken: pc already points past the BNE.D.
        bp_q <= 1'b0;
        if (bus.br_taken) pc_q <= {1'b0, bus.br_target};
      end else if (issue_cyc) begin
        pc_q <= pc_q + (AW+1)'(n_cons);
        bp_q <= br_hit;
      end
    end
  end

  assign bus.issue_valid    = iv_q;
  assign bus.issue_class    = cls_q;
  assign bus.issue_inst     = inst_q;
  assign bus.issue_pc       = pcs_q;
  assign bus.pc             = pc_q;
  assign bus.branch_pending = bp_q;
  assign bus.done           = (pc_q >= bus.prog_len) && !bp_q;
endmodule

// File: doc/issue_queue.md
# issue_queue

Parametrised in-order instruction issue unit for the Tomasulo core. It holds the program in an internal instruction store and issues up to `ISSUE_W` instructions per cycle to the adder reservation stations, load buffers and store buffers. Issue is gated by per-class free-entry counts, and it stops behind an unresolved `BNE.D` until the branch unit resolves it. It sits between program load and the reservation stations / load-store buffers.

## Interface
- `IW`, 16, instruction width; the encoding is fixed in the low 16 bits: `[15:10]` imm, `[9:7]` Rx, `[6:4]` Ry, `[3:0]` opcode.
- `DEPTH`, 64, instruction store entries; must be a power of two.
- `ISSUE_W`, 2, issue slots per cycle; legal values are 1 to 4.
- `FREE_W`, 3, width of each free-entry count.
- `AW`, `$clog2(DEPTH)`, PC width (derived).

Ports (one clock; reset is synchronous and active-high):
- `Clock` in 1: sole clock, rising edge.
- `Reset` in 1: synchronous, active-high.
- `Run` in 1: issue enable.
- `prog_we` in 1: instruction store write strobe.
- `prog_addr` in AW: write address.
- `prog_data` in IW: write data.
- `prog_len` in AW+1: number of valid instructions; held stable while `Run`=1.
- `add_free`, `ld_free`, `sd_free` in FREE_W each: free entries in the adder RS, load buffer and store buffer.
- `br_resolve` in 1: branch outcome valid, one-cycle pulse.
- `br_taken` in 1: branch taken.
- `br_target` in AW: target PC when taken.
- `issue_valid` out ISSUE_W: slot k carries an instruction.
- `issue_class` out 2*ISSUE_W: per slot, 00=adder, 01=load, 10=store, 11=none.
- `issue_inst` out IW*ISSUE_W: per slot, the raw instruction.
- `issue_pc` out AW*ISSUE_W: per slot, the instruction's PC.
- `pc` out AW+1: next PC to issue.
- `branch_pending` out 1: a BNE.D has issued and is not yet resolved.
- `done` out 1: high when `pc >= prog_len` and `branch_pending`=0.

## Operation
- Opcode classes: ADD.D (0000), SUB.D (0001) and BNE.D (0010) go to the adder. L.D (0011) goes to load. S.D (0100) goes to store. Any other opcode is class 11: it consumes its slot and PC, issues nothing, and leaves `issue_valid[k]`=0.
- Instruction store: written synchronously when `prog_we`=1, in any state including during `Run`. It is read asynchronously at `pc+k`. Its contents are not cleared by `Reset`.
- An issue cycle requires `Run`=1, `Reset`=0, `branch_pending`=0 and `br_resolve`=0. In that cycle slots are evaluated in order k=0..ISSUE_W-1.
- Slot k issues only if all of the following hold:
  - every earlier slot issued or was consumed as class 11;
  - `pc+k < prog_len`;
  - the class's free count is strictly greater than the number of same-class instructions in earlier slots this cycle;
  - no earlier slot this cycle was a BNE.D.
- The first slot that fails a check ends issue for that cycle (in-order, no skipping).
- `pc` advances by the number of consumed slots.
- When a BNE.D issues, `branch_pending` is set. Later slots in that cycle stay empty.
- When `br_resolve`=1 and `branch_pending`=1: `pc` becomes `br_target` if `br_taken`=1, otherwise it is unchanged (it already points past the BNE). `branch_pending` clears. Nothing issues in that cycle.
- `br_resolve` is ignored when `branch_pending`=0.
- A `br_target >= prog_len` is legal; the unit simply goes `done`.
- `Run`=0 holds `pc` and `branch_pending` and drives all `issue_valid` to 0.

## Timing
- All outputs are registered and update on the rising edge of `Clock`. Issue outputs are valid for exactly one cycle per issue; there is no back-pressure beyond the free counts.
- Latency from an issue cycle to `issue_valid` high is 1 edge.
- Latency from `br_resolve` to the first issue at the new PC is 2 edges: the resolve edge, then the issue edge.
- Reset (takes priority over everything): `pc`=0, `branch_pending`=0, `issue_valid`=0, `issue_class`=all 11, `issue_inst`=0, `issue_pc`=0. `done` reflects the reset `pc` against `prog_len`.
- Reset mid-branch discards the pending branch. A `br_resolve` in the reset cycle is ignored.
- The free counts are sampled in the issue cycle. The consumer is responsible for decrementing them one cycle later; the unit does not track in-flight entries.
- PC arithmetic uses AW+1 bits, so `pc` can reach `DEPTH` without wrapping. The read address is `pc[AW-1:0]`, and slots at or past `prog_len` are never issued.

## Test plan
- **Dual issue:** ISSUE_W=2, program ADD,SUB,LD,SD, all free=4, Run=1 → cycle 1 issues pc0/1 (classes 00,00), cycle 2 issues pc2/3 (01,10). `pc`=4, then `done`=1.
- **Structural stall:** `add_free`=1, program ADD,ADD → cycle 1 issues only slot 0. Raise `add_free` to 1 again → the next cycle issues pc1.
- **Branch:** program ADD,BNE,LD,SD,ADD. The BNE issues in slot 1, then `branch_pending`=1 and nothing issues for 3 cycles. Pulse `br_resolve`, `br_taken`=1, `br_target`=4 → two edges later pc4 ADD issues. Repeat with `br_taken`=0 → resumes at pc2.
- **Illegal opcode:** opcode 1111 at pc0, ADD at pc1 → `issue_valid`=10, meaning slot 0 is empty and slot 1 is the ADD; `pc` advances by 2.
- **Reset mid-operation:** assert `Reset` while `branch_pending`=1 and `pc`=5 → next edge `pc`=0, `branch_pending`=0, all `issue_valid`=0. Store contents are retained and re-issue from pc0.
- **Width and boundary:** ISSUE_W=4, DEPTH=8, `prog_len`=8, then `prog_len`=6 → the final cycle issues only pc4/5, `pc` stops at 6, and `done`=1. Also: `Run`=0 in mid-program holds `pc`.
